// File: rtl/detectar_baterias_descargada.sv
// Dual-channel low-battery detector: per-channel OK/LOW state machine with
// threshold, hysteresis band and consecutive-sample filter, plus sticky flags.
module detectar_baterias_descargada #(
    parameter int WIDTH         = 4,
    parameter int LOW_THRESH    = 0,
    parameter int HYST          = 0,
    parameter int FILTER_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] carga_bateria1,
    input  logic [WIDTH-1:0] carga_bateria2,
    input  logic             clear_latch,
    output logic             advertencia_bateria_1,
    output logic             advertencia_bateria_2,
    output logic             advertencia_ambas,
    output logic             latch_bateria_1,
    output logic             latch_bateria_2
);

    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);

    // Limits are held one bit wider than the charge so LOW_THRESH+1+HYST cannot wrap.
    localparam logic [WIDTH:0] LOW_LIM  = (WIDTH+1)'(LOW_THRESH);
    localparam logic [WIDTH:0] HIGH_LIM = (WIDTH+1)'(LOW_THRESH + 1 + HYST);
    localparam logic [CNT_W:0] FILT_LIM = (CNT_W+1)'(FILTER_CYCLES);
    localparam logic [CNT_W:0] CNT_STEP = (CNT_W+1)'(1);
    localparam logic [CNT_W-1:0] CNT_INC  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    generate
        if (FILTER_CYCLES < 1) begin : g_bad_filter
            $error("FILTER_CYCLES must be at least 1");
        end
        if (LOW_THRESH + 1 + HYST > (2 ** WIDTH) - 1) begin : g_bad_thresh
            $error("LOW_THRESH + 1 + HYST must not exceed 2^WIDTH - 1");
        end
    endgenerate

    typedef enum logic {
        ST_OK  = 1'b0,
        ST_LOW = 1'b1
    } chan_state_e;

    chan_state_e      state_r     [2];
    chan_state_e      state_nxt_s [2];
    logic [CNT_W-1:0] cnt_r       [2];
    logic [CNT_W-1:0] cnt_nxt_s   [2];
    logic [WIDTH:0]   carga_s     [2];
    logic [1:0]       low_cond_s;
    logic [1:0]       high_cond_s;
    logic [1:0]       warn_nxt_s;
    logic [1:0]       latch_r;
    logic             ambas_r;

    // Next-state and filter-counter logic for both channels.
    always_comb begin
        carga_s[0] = {1'b0, carga_bateria1};
        carga_s[1] = {1'b0, carga_bateria2};
        low_cond_s  = 2'b00;
        high_cond_s = 2'b00;
        warn_nxt_s  = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            low_cond_s[ch]  = (carga_s[ch] <= LOW_LIM);
            high_cond_s[ch] = (carga_s[ch] >= HIGH_LIM);
            state_nxt_s[ch] = state_r[ch];
            cnt_nxt_s[ch]   = CNT_ZERO;
            case (state_r[ch])
                ST_OK: begin
                    if (low_cond_s[ch]) begin
                        if (({1'b0, cnt_r[ch]} + CNT_STEP) == FILT_LIM) begin
                            state_nxt_s[ch] = ST_LOW;
                            cnt_nxt_s[ch]   = CNT_ZERO;
                        end else begin
                            cnt_nxt_s[ch] = cnt_r[ch] + CNT_INC;
                        end
                    end else begin
                        cnt_nxt_s[ch] = CNT_ZERO;
                    end
                end
                ST_LOW: begin
                    // Anything short of high_cond (band or still low) restarts the release count.
                    if (high_cond_s[ch]) begin
                        if (({1'b0, cnt_r[ch]} + CNT_STEP) == FILT_LIM) begin
                            state_nxt_s[ch] = ST_OK;
                            cnt_nxt_s[ch]   = CNT_ZERO;
                        end else begin
                            cnt_nxt_s[ch] = cnt_r[ch] + CNT_INC;
                        end
                    end else begin
                        cnt_nxt_s[ch] = CNT_ZERO;
                    end
                end
                default: begin
                    state_nxt_s[ch] = ST_OK;
                    cnt_nxt_s[ch]   = CNT_ZERO;
                end
            endcase
            warn_nxt_s[ch] = (state_nxt_s[ch] == ST_LOW);
        end
    end

    // State, counter, combined warning and sticky-flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < 2; ch++) begin
                state_r[ch] <= ST_OK;
                cnt_r[ch]   <= CNT_ZERO;
            end
            latch_r <= 2'b00;
            ambas_r <= 1'b0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                state_r[ch] <= state_nxt_s[ch];
                cnt_r[ch]   <= cnt_nxt_s[ch];
            end
            // A set on the same edge as clear_latch takes priority.
            latch_r <= warn_nxt_s | (latch_r & {2{~clear_latch}});
            ambas_r <= warn_nxt_s[0] & warn_nxt_s[1];
        end
    end

    assign advertencia_bateria_1 = (state_r[0] == ST_LOW);
    assign advertencia_bateria_2 = (state_r[1] == ST_LOW);
    assign advertencia_ambas     = ambas_r;
    assign latch_bateria_1       = latch_r[0];
    assign latch_bateria_2       = latch_r[1];

endmodule

// File: tb/tb_detectar_baterias_descargada.sv
// Scoreboard bench: one default-parameter instance and one filtered/hysteresis
// instance; the driver queues expected outputs, the monitor pops and compares.
module tb_detectar_baterias_descargada;

    logic       clk;
    logic       rst;
    logic [3:0] a1, a2, b1, b2;
    logic       clra, clrb;
    logic       a_w1, a_w2, a_amb, a_l1, a_l2;
    logic       b_w1, b_w2, b_amb, b_l1, b_l2;

    typedef struct {
        logic [4:0] exp_a;
        logic [4:0] exp_b;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    event chk_ev;
    int   checks = 0;
    int   errors = 0;

    detectar_baterias_descargada u_dut_a (
        .clk                   (clk),
        .rst                   (rst),
        .carga_bateria1        (a1),
        .carga_bateria2        (a2),
        .clear_latch           (clra),
        .advertencia_bateria_1 (a_w1),
        .advertencia_bateria_2 (a_w2),
        .advertencia_ambas     (a_amb),
        .latch_bateria_1       (a_l1),
        .latch_bateria_2       (a_l2)
    );

    detectar_baterias_descargada #(
        .WIDTH(4), .LOW_THRESH(2), .HYST(3), .FILTER_CYCLES(3)
    ) u_dut_b (
        .clk                   (clk),
        .rst                   (rst),
        .carga_bateria1        (b1),
        .carga_bateria2        (b2),
        .clear_latch           (clrb),
        .advertencia_bateria_1 (b_w1),
        .advertencia_bateria_2 (b_w2),
        .advertencia_ambas     (b_amb),
        .latch_bateria_1       (b_l1),
        .latch_bateria_2       (b_l2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected packing: {warning1, warning2, ambas, latch1, latch2}
    task automatic step(input string name, input logic [4:0] ea, input logic [4:0] eb);
        exp_t e;
        e.exp_a = ea;
        e.exp_b = eb;
        e.name  = name;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compares one queued expectation after each edge or async event.
    initial begin
        exp_t       e;
        logic [4:0] got_a, got_b;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got_a = {a_w1, a_w2, a_amb, a_l1, a_l2};
                got_b = {b_w1, b_w2, b_amb, b_l1, b_l2};
                checks++;
                if (got_a !== e.exp_a) begin
                    errors++;
                    $display("FAIL %s dut_a got %b expected %b", e.name, got_a, e.exp_a);
                end
                checks++;
                if (got_b !== e.exp_b) begin
                    errors++;
                    $display("FAIL %s dut_b got %b expected %b", e.name, got_b, e.exp_b);
                end
            end
        end
    end

    // Driver: directed vectors, inputs change on the falling edge.
    initial begin
        rst = 1'b1; clra = 1'b0; clrb = 1'b0;
        a1 = 4'd10; a2 = 4'd6; b1 = 4'd10; b2 = 4'd10;
        step("reset", 5'b00000, 5'b00000);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("idle_10_6", 5'b00000, 5'b00000);

        a1 = 4'd0;  a2 = 4'd6;  step("b1_low", 5'b10010, 5'b00000);
        a1 = 4'd9;  a2 = 4'd0;  step("swap_9_0", 5'b01011, 5'b00000);
        a1 = 4'd0;  a2 = 4'd0;  step("both_low", 5'b11111, 5'b00000);
        a1 = 4'd1;  a2 = 4'd1;  step("release_at_1", 5'b00011, 5'b00000);
        a1 = 4'd0;  a2 = 4'd0;  step("both_low_again", 5'b11111, 5'b00000);
        a1 = 4'd15; a2 = 4'd15; step("release_15", 5'b00011, 5'b00000);
        clra = 1'b1;            step("clear_latch", 5'b00000, 5'b00000);
        a1 = 4'd0;              step("set_wins", 5'b10010, 5'b00000);
        clra = 1'b0;
        a2 = 4'd0;              step("both_hold", 5'b11111, 5'b00000);

        // Asynchronous reset mid-cycle, checked before any clock edge.
        #2;
        rst = 1'b1;
        begin
            exp_t e;
            e.exp_a = 5'b00000;
            e.exp_b = 5'b00000;
            e.name  = "async_reset";
            sb_q.push_back(e);
        end
        -> chk_ev;
        @(negedge clk);
        rst = 1'b0;
        a1 = 4'd10; a2 = 4'd6;  step("after_reset", 5'b00000, 5'b00000);

        // Filtered channel: LOW_THRESH=2, HYST=3, FILTER_CYCLES=3.
        b1 = 4'd2; step("flt_2", 5'b00000, 5'b00000);
        b1 = 4'd2; step("flt_2b", 5'b00000, 5'b00000);
        b1 = 4'd1; step("flt_warn", 5'b00000, 5'b10010);
        b1 = 4'd2; step("hold_2", 5'b00000, 5'b10010);
        b1 = 4'd0; step("hold_0", 5'b00000, 5'b10010);
        b1 = 4'd2; step("hold_2b", 5'b00000, 5'b10010);
        b1 = 4'd4; step("band_4", 5'b00000, 5'b10010);
        b1 = 4'd6; step("rel_6a", 5'b00000, 5'b10010);
        b1 = 4'd6; step("rel_6b", 5'b00000, 5'b10010);
        b1 = 4'd6; step("rel_6c", 5'b00000, 5'b00010);
        b1 = 4'd0; step("int_0a", 5'b00000, 5'b00010);
        b1 = 4'd0; step("int_0b", 5'b00000, 5'b00010);
        b1 = 4'd7; step("int_7", 5'b00000, 5'b00010);
        b1 = 4'd0; step("int_0c", 5'b00000, 5'b00010);
        b1 = 4'd0; step("int_0d", 5'b00000, 5'b00010);
        b1 = 4'd0; step("int_warn", 5'b00000, 5'b10010);
        clrb = 1'b1; b1 = 4'd15;
        step("b_rel_clear", 5'b00000, 5'b10010);
        clrb = 1'b0;
        step("b_rel_clear2", 5'b00000, 5'b10010);
        step("b_released", 5'b00000, 5'b00010);

        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain queue_left %0d expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
